hdr_frame_counter: RTL and testbench

- Parametrised successor to the CCC handler's frame counter: tracks the remaining HDR-DDR data words of one transfer.
- Derives the word total from the command descriptor: regular uses DATA_LEN, immediate uses DTT.
- Decrements once per completed word, flags the last word (direction-aware), pulses done and flags overrun.
- Sits between the register-file command decode and the HDR TX/RX engines, alongside the bit counter.

---
 rtl/hdr_fcnt_pkg.sv | 17 +
 rtl/hdr_frame_counter.sv | 79 +++++++
 tb/tb_hdr_frame_counter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdr_fcnt_pkg.sv
// hdr_fcnt_pkg: shared types and constants for the HDR-DDR frame counter.
package hdr_fcnt_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} fcnt_state_e;

    // Word count per immediate DTT, 2 bits per entry, entry 0 in the LSBs.
    localparam logic [15:0] DTT_WORDS = {2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};

    localparam int THRESH_RX        = 1;
    localparam int THRESH_TX        = 2;
    localparam int WORD_END_DEFAULT = 19;

    function automatic logic [1:0] dtt_words(input logic [2:0] dtt);
        return DTT_WORDS[{dtt, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/hdr_frame_counter.sv
// hdr_frame_counter: counts remaining HDR-DDR words of a transfer, flags the
// last word, pulses done on completion and latches overrun.
module hdr_frame_counter
    import hdr_fcnt_pkg::*;
#(
    parameter int LEN_W        = 16,
    parameter int CNT_W        = 16,
    parameter int BITCNT_W     = 6,
    parameter int WORD_END_BIT = WORD_END_DEFAULT
) (
    input  logic                i_fcnt_clk,
    input  logic                i_fcnt_rst,
    input  logic                i_fcnt_load,
    input  logic                i_fcnt_en,
    input  logic                i_fcnt_dir,
    input  logic                i_regf_CMD_ATTR,
    input  logic [LEN_W-1:0]    i_regf_DATA_LEN,
    input  logic [2:0]          i_regf_DTT,
    input  logic [BITCNT_W-1:0] i_cnt_bit_count,
    output logic [CNT_W-1:0]    o_fcnt_remaining,
    output logic                o_fcnt_last_frame,
    output logic                o_fcnt_done,
    output logic                o_fcnt_err_overrun
);

    fcnt_state_e         state, state_n;
    logic [CNT_W-1:0]    rem_n, total, thresh;
    logic [LEN_W:0]      len_p1;
    logic [BITCNT_W-1:0] prev_bitcnt;
    logic                tick, last_n, done_n, ovr_n;

    // Rising into the end-bit value only, so a stalled bit count ticks once.
    assign tick   = i_fcnt_en && i_cnt_bit_count == BITCNT_W'(WORD_END_BIT)
                    && prev_bitcnt != BITCNT_W'(WORD_END_BIT);
    assign len_p1 = {1'b0, i_regf_DATA_LEN} + (LEN_W+1)'(1);
    assign total  = i_regf_CMD_ATTR ? CNT_W'(dtt_words(i_regf_DTT)) : CNT_W'(len_p1[LEN_W:1]);
    assign thresh = i_fcnt_dir ? CNT_W'(THRESH_TX) : CNT_W'(THRESH_RX);

    always_comb begin
        state_n = state;
        rem_n   = o_fcnt_remaining;
        done_n  = 1'b0;
        ovr_n   = o_fcnt_err_overrun;
        if (i_fcnt_load) begin
            rem_n   = total;
            ovr_n   = 1'b0;
            state_n = (total != '0) ? COUNT : DONE;
            done_n  = (total == '0);
        end else if (tick && state == COUNT) begin
            rem_n = o_fcnt_remaining - CNT_W'(1);
            if (o_fcnt_remaining == CNT_W'(1)) begin
                state_n = DONE;
                done_n  = 1'b1;
            end
        end else if (tick && state == DONE) begin
            ovr_n = 1'b1;
        end
        last_n = state_n == COUNT && rem_n != '0 && rem_n <= thresh;
    end

    always_ff @(posedge i_fcnt_clk) begin
        if (i_fcnt_rst) begin
            state              <= IDLE;
            prev_bitcnt        <= '0;
            o_fcnt_remaining   <= '0;
            o_fcnt_last_frame  <= 1'b0;
            o_fcnt_done        <= 1'b0;
            o_fcnt_err_overrun <= 1'b0;
        end else begin
            state              <= state_n;
            prev_bitcnt        <= i_cnt_bit_count;
            o_fcnt_remaining   <= rem_n;
            o_fcnt_last_frame  <= last_n;
            o_fcnt_done        <= done_n;
            o_fcnt_err_overrun <= ovr_n;
        end
    end

endmodule

// File: tb/tb_hdr_frame_counter.sv
// tb_hdr_frame_counter: directed and random checks of hdr_frame_counter
// against a word-level reference model.
module tb_hdr_frame_counter;

    logic        clk = 1'b0, rst = 1'b0, load = 1'b0, en = 1'b0, dir = 1'b0, attr = 1'b0;
    logic [15:0] len = '0;
    logic [2:0]  dtt = '0;
    logic [5:0]  bc = '0;
    logic [15:0] rem;
    logic        last, done, ovr;

    int tests = 0, fails = 0;

    // Reference model: words left, whether a transfer is still counting,
    // whether it has finished, plus the last bit count seen.
    int m_rem = 0, m_prev = 0;
    bit m_counting = 0, m_finished = 0, m_last = 0, m_done = 0, m_ovr = 0;
    int dtt_tab [8] = '{0, 1, 1, 2, 2, 1, 2, 2};

    hdr_frame_counter dut (
        .i_fcnt_clk(clk), .i_fcnt_rst(rst), .i_fcnt_load(load), .i_fcnt_en(en),
        .i_fcnt_dir(dir), .i_regf_CMD_ATTR(attr), .i_regf_DATA_LEN(len),
        .i_regf_DTT(dtt), .i_cnt_bit_count(bc), .o_fcnt_remaining(rem),
        .o_fcnt_last_frame(last), .o_fcnt_done(done), .o_fcnt_err_overrun(ovr)
    );

    always #5 clk = ~clk;

    // Advance one clock, update the model from the applied inputs, settle, drop load.
    task automatic step();
        bit is_tick;
        int total;
        @(posedge clk);
        is_tick = en && bc == 19 && m_prev != 19;
        m_prev  = bc;
        m_done  = 0;
        if (rst) begin
            m_rem = 0; m_prev = 0; m_counting = 0; m_finished = 0; m_ovr = 0;
        end else if (load) begin
            total      = attr ? dtt_tab[dtt] : (int'(len) + 1) / 2;
            m_rem      = total;
            m_ovr      = 0;
            m_counting = total > 0;
            m_finished = total == 0;
            m_done     = total == 0;
        end else if (is_tick && m_counting) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_counting = 0; m_finished = 1; m_done = 1;
            end
        end else if (is_tick && m_finished) begin
            m_ovr = 1;
        end
        m_last = m_counting && m_rem >= 1 && m_rem <= (dir ? 2 : 1);
        #1;
        load = 1'b0;
    endtask

    task automatic do_load(input bit a, input logic [15:0] l, input logic [2:0] d);
        attr = a; len = l; dtt = d; load = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; bc = '0;
        step(); step();
        tests++;
        if ({rem, last, done, ovr} !== 19'd0) begin
            fails++;
            $display("FAIL reset: rem=%0h last=%b done=%b ovr=%b, want all 0", rem, last, done, ovr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_regular_rx();
        int done_count = 0;
        dir = 1'b0; en = 1'b1; bc = 6'd0;
        do_load(1'b0, 16'd5, 3'd0);
        step();
        tests++;
        if (rem !== 16'd3 || last !== 1'b0) begin
            fails++; $display("FAIL rx_load: rem=%0d last=%b, want rem=3 last=0", rem, last);
        end
        for (int i = 0; i < 6; i++) begin
            bc = (i % 2 == 0) ? 6'd19 : 6'd0;
            step();
            done_count += int'(done);
            tests++;
            if ({rem, last, done, ovr} !== {m_rem[15:0], m_last, m_done, m_ovr}) begin
                fails++;
                $display("FAIL rx_seq %0d: rem=%0d last=%b done=%b ovr=%b, want %0d %b %b %b",
                         i, rem, last, done, ovr, m_rem, m_last, m_done, m_ovr);
            end
        end
        tests++;
        if (done_count != 1 || rem !== 16'd0) begin
            fails++; $display("FAIL rx_done: pulses=%0d rem=%0d, want 1 pulse rem=0", done_count, rem);
        end
    endtask

    task automatic test_regular_tx();
        dir = 1'b1; en = 1'b1; bc = 6'd0;
        do_load(1'b0, 16'd5, 3'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            bc = (i % 2 == 0) ? 6'd19 : 6'd0;
            step();
            tests++;
            if ({rem, last, done, ovr} !== {m_rem[15:0], m_last, m_done, m_ovr}) begin
                fails++;
                $display("FAIL tx_seq %0d: rem=%0d last=%b done=%b ovr=%b, want %0d %b %b %b",
                         i, rem, last, done, ovr, m_rem, m_last, m_done, m_ovr);
            end
            if (i == 0) begin
                tests++;
                if (rem !== 16'd2 || last !== 1'b1) begin
                    fails++; $display("FAIL tx_early_last: rem=%0d last=%b, want rem=2 last=1", rem, last);
                end
            end
        end
    endtask

    task automatic test_immediate();
        dir = 1'b0; en = 1'b1; bc = 6'd0;
        do_load(1'b1, 16'd0, 3'd0);
        step();
        tests++;
        if (done !== 1'b1 || last !== 1'b0 || rem !== 16'd0) begin
            fails++; $display("FAIL dtt0: done=%b last=%b rem=%0d, want done=1 last=0 rem=0", done, last, rem);
        end
        step();
        tests++;
        if (done !== 1'b0 || last !== 1'b0) begin
            fails++; $display("FAIL dtt0_after: done=%b last=%b, want 0 0", done, last);
        end
        do_load(1'b1, 16'd0, 3'd6);
        step();
        tests++;
        if (rem !== 16'd2 || done !== 1'b0) begin
            fails++; $display("FAIL dtt6: rem=%0d done=%b, want rem=2 done=0", rem, done);
        end
    endtask

    task automatic test_stall();
        logic [5:0] pat [6] = '{6'd19, 6'd19, 6'd19, 6'd19, 6'd0, 6'd19};
        dir = 1'b0; en = 1'b1; bc = 6'd0;
        do_load(1'b0, 16'd10, 3'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            bc = pat[i];
            step();
        end
        tests++;
        if (rem !== 16'd3 || rem !== m_rem[15:0]) begin
            fails++; $display("FAIL stall: rem=%0d, want 3", rem);
        end
    endtask

    task automatic test_enable_overrun();
        dir = 1'b0; en = 1'b1; bc = 6'd0;
        do_load(1'b0, 16'd1, 3'd0);
        step();
        en = 1'b0; bc = 6'd19;
        step();
        tests++;
        if (rem !== 16'd1 || done !== 1'b0) begin
            fails++; $display("FAIL en_low: rem=%0d done=%b, want rem=1 done=0", rem, done);
        end
        bc = 6'd0; step();
        en = 1'b1; bc = 6'd19; step();
        tests++;
        if (rem !== 16'd0 || done !== 1'b1 || ovr !== 1'b0) begin
            fails++; $display("FAIL en_tick: rem=%0d done=%b ovr=%b, want 0 1 0", rem, done, ovr);
        end
        bc = 6'd0; step();
        bc = 6'd19; step();
        tests++;
        if (ovr !== 1'b1 || rem !== 16'd0 || done !== 1'b0) begin
            fails++; $display("FAIL overrun: ovr=%b rem=%0d done=%b, want 1 0 0", ovr, rem, done);
        end
        bc = 6'd0; step(); step();
        tests++;
        if (ovr !== 1'b1) begin
            fails++; $display("FAIL overrun_sticky: ovr=%b, want 1", ovr);
        end
        do_load(1'b0, 16'd4, 3'd0);
        step();
        tests++;
        if (ovr !== 1'b0 || rem !== 16'd2) begin
            fails++; $display("FAIL overrun_clear: ovr=%b rem=%0d, want 0 2", ovr, rem);
        end
    endtask

    task automatic test_back_to_back();
        dir = 1'b0; en = 1'b1; bc = 6'd0;
        do_load(1'b0, 16'd8, 3'd0);
        step();
        bc = 6'd19; step();
        bc = 6'd0; step();
        bc = 6'd19;
        do_load(1'b0, 16'hFFFF, 3'd0);
        step();
        tests++;
        if (rem !== 16'h8000 || done !== 1'b0 || last !== 1'b0) begin
            fails++; $display("FAIL reload_max: rem=%0h done=%b last=%b, want 8000 0 0", rem, done, last);
        end
        bc = 6'd0; step();
        bc = 6'd19; step();
        rst = 1'b1; step();
        tests++;
        if ({rem, last, done, ovr} !== 19'd0) begin
            fails++;
            $display("FAIL mid_reset: rem=%0h last=%b done=%b ovr=%b, want all 0", rem, last, done, ovr);
        end
        rst = 1'b0; bc = 6'd0; step();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 11) == 0);
            en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            attr = $urandom_range(0, 1);
            len  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
            dtt  = 3'($urandom_range(0, 7));
            bc   = ($urandom_range(0, 2) == 0) ? 6'd19 : 6'($urandom_range(0, 18));
            step();
            tests++;
            if ({rem, last, done, ovr} !== {m_rem[15:0], m_last, m_done, m_ovr}) begin
                fails++;
                if (bad++ < 10)
                    $display("FAIL random %0d: rem=%0h last=%b done=%b ovr=%b, want %0h %b %b %b",
                             i, rem, last, done, ovr, m_rem, m_last, m_done, m_ovr);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_regular_rx();
        test_regular_tx();
        test_immediate();
        test_stall();
        test_enable_overrun();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
